// File: rtl/muldiv_unit.sv
// muldiv_unit -- iterative RV32M multiply/divide execution unit.
//
// Operands are taken as magnitudes plus sign flags when accepted. Multiply
// uses one shift-add step per cycle. Divide uses one restoring-division step
// per cycle. The signs are applied when the result is written back. The
// result leaves as a registered one-cycle write-back strobe that drives the
// register file write port directly.
//
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   start             request, sampled only while idle
//   funct3            000 MUL, 001 MULH, 010 MULHSU, 011 MULHU,
//                     100 DIV, 101 DIVU, 110 REM, 111 REMU
//   rs1_val, rs2_val  operand A (dividend/multiplicand), operand B
//   rd_addr           destination register, frozen at accept
//   busy              high from the cycle after accept through write-back
//   wr_en             one-cycle write-back strobe
//   wr_addr, wr_data  destination and result; both hold after the strobe
//
// Optional build macro MULDIV_EARLY_OUT_EN: multiplies by zero,
// divide-by-zero and signed-overflow divides go straight from IDLE to DONE.
// Results are the same with and without it. Only the latency changes.

module muldiv_unit #(
  parameter int D_WIDTH       = 32,
  parameter int ADDRESS_WIDTH = 5
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [2:0]               funct3,
  input  logic [D_WIDTH-1:0]       rs1_val,
  input  logic [D_WIDTH-1:0]       rs2_val,
  input  logic [ADDRESS_WIDTH-1:0] rd_addr,
  output logic                     busy,
  output logic                     wr_en,
  output logic [ADDRESS_WIDTH-1:0] wr_addr,
  output logic [D_WIDTH-1:0]       wr_data
);

  localparam int CW = (D_WIDTH > 1) ? $clog2(D_WIDTH) : 1;
  localparam logic [CW-1:0] LAST_ITER = CW'(D_WIDTH - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]               state_q, state_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic [2:0]               op_q, op_d;
  logic [ADDRESS_WIDTH-1:0] rd_q, rd_d;
  logic [D_WIDTH-1:0]       opnd_q, opnd_d;    // multiplicand or divisor magnitude
  logic [2*D_WIDTH-1:0]     acc_q, acc_d;      // {hi, lo} product or {remainder, quotient}
  logic                     neg_q, neg_d;      // negate product / quotient
  logic                     rneg_q, rneg_d;    // negate remainder (dividend sign)
  logic                     busy_q, busy_d;
  logic                     wr_en_q, wr_en_d;
  logic [ADDRESS_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [D_WIDTH-1:0]       wr_data_q, wr_data_d;

  // Operand decode for the request being presented
  logic               a_signed, b_signed, a_neg, b_neg, is_mul_in, div_zero_in;
  logic [D_WIDTH-1:0] a_mag, b_mag;

  always_comb begin
    a_signed = 1'b0;
    b_signed = 1'b0;
    case (funct3)
      3'b000, 3'b001, 3'b100, 3'b110: begin
        a_signed = 1'b1;
        b_signed = 1'b1;
      end
      3'b010:  a_signed = 1'b1;
      default: ;
    endcase
  end

  assign a_neg       = a_signed & rs1_val[D_WIDTH-1];
  assign b_neg       = b_signed & rs2_val[D_WIDTH-1];
  assign a_mag       = a_neg ? -rs1_val : rs1_val;
  assign b_mag       = b_neg ? -rs2_val : rs2_val;
  assign is_mul_in   = ~funct3[2];
  assign div_zero_in = (rs2_val == '0);

`ifdef MULDIV_EARLY_OUT_EN
  logic mul_zero_in, ovf_in;
  assign mul_zero_in = is_mul_in & ((rs1_val == '0) | div_zero_in);
  // Only DIV/REM have both operands signed among the divide ops.
  assign ovf_in = ~is_mul_in & a_signed & b_signed &
                  (rs1_val == {1'b1, {(D_WIDTH-1){1'b0}}}) & (rs2_val == '1);
`endif

  logic [D_WIDTH:0]     mul_sum, div_diff;
  logic [2*D_WIDTH-1:0] prod;
  logic [D_WIDTH-1:0]   quo, rem, result;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    rd_d      = rd_q;
    opnd_d    = opnd_q;
    acc_d     = acc_q;
    neg_d     = neg_q;
    rneg_d    = rneg_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;

    // Shift-add: add the multiplicand into the high half when the current
    // multiplier bit (acc lsb) is set, then shift everything right by one.
    mul_sum  = {1'b0, acc_q[2*D_WIDTH-1:D_WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    // Restoring step: trial-subtract the divisor from the left-shifted
    // partial remainder. That remainder needs one extra bit.
    div_diff = acc_q[2*D_WIDTH-1:D_WIDTH-1] - {1'b0, opnd_q};

    case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d   = funct3;
          rd_d   = rd_addr;
          rneg_d = a_neg;
          // A zero divisor must give an all-ones quotient whatever the signs.
          neg_d  = (a_neg ^ b_neg) & (is_mul_in | ~div_zero_in);
          cnt_d  = '0;
          state_d = S_CALC;
          if (is_mul_in) begin
            opnd_d = a_mag;
            acc_d  = {{D_WIDTH{1'b0}}, b_mag};
          end else begin
            opnd_d = b_mag;
            acc_d  = {{D_WIDTH{1'b0}}, a_mag};
          end
`ifdef MULDIV_EARLY_OUT_EN
          // Preload the accumulator with the state the full iteration
          // would reach, so that write-back is shared with the normal path.
          if (mul_zero_in) begin
            acc_d   = '0;
            state_d = S_DONE;
          end else if (!is_mul_in && div_zero_in) begin
            acc_d   = {a_mag, {D_WIDTH{1'b1}}};
            state_d = S_DONE;
          end else if (ovf_in) begin
            // Quotient magnitude equals the dividend magnitude. The remainder is 0.
            state_d = S_DONE;
          end
`endif
        end
      end
      S_CALC: begin
        if (op_q[2]) begin
          if (!div_diff[D_WIDTH])
            acc_d = {div_diff[D_WIDTH-1:0], acc_q[D_WIDTH-2:0], 1'b1};
          else
            acc_d = {acc_q[2*D_WIDTH-2:0], 1'b0};
        end else begin
          acc_d = {mul_sum, acc_q[D_WIDTH-1:1]};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_ITER) begin
          cnt_d   = '0;
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // The result is formed from next-state values, so it is registered on
    // the same edge that enters DONE.
    prod = neg_d  ? -acc_d : acc_d;
    quo  = neg_d  ? -acc_d[D_WIDTH-1:0] : acc_d[D_WIDTH-1:0];
    rem  = rneg_d ? -acc_d[2*D_WIDTH-1:D_WIDTH] : acc_d[2*D_WIDTH-1:D_WIDTH];
    case (op_d)
      3'b000:                 result = prod[D_WIDTH-1:0];
      3'b001, 3'b010, 3'b011: result = prod[2*D_WIDTH-1:D_WIDTH];
      3'b100, 3'b101:         result = quo;
      default:                result = rem;
    endcase

    if (state_d == S_DONE) begin
      wr_addr_d = rd_d;
      wr_data_d = result;
    end
    wr_en_d = (state_d == S_DONE);
    busy_d  = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      op_q      <= '0;
      rd_q      <= '0;
      opnd_q    <= '0;
      acc_q     <= '0;
      neg_q     <= 1'b0;
      rneg_q    <= 1'b0;
      busy_q    <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      rd_q      <= rd_d;
      opnd_q    <= opnd_d;
      acc_q     <= acc_d;
      neg_q     <= neg_d;
      rneg_q    <= rneg_d;
      busy_q    <= busy_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign busy    = busy_q;
  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;

endmodule
